// File: rtl/conv23_pool_write_controller_pkg.sv
// Shared constants and helpers for the CONV2/CONV3 pooled write path.
package conv23_pool_write_controller_pkg;

   localparam int DW_DEFAULT   = 16;
   localparam int NCH_DEFAULT  = 112;

   // Conv output geometry of the two layers this controller serves
   localparam int CONV2_WIDTH  = 14;
   localparam int CONV2_HEIGHT = 18;
   localparam int CONV3_WIDTH  = 6;
   localparam int CONV3_HEIGHT = 8;

   // Pool quadrant within a 2x2 window, in arrival order
   typedef enum logic [1:0] {
      POOL_Q0 = 2'd0,
      POOL_Q1 = 2'd1,
      POOL_Q2 = 2'd2,
      POOL_Q3 = 2'd3
   } pool_quad_e;

   // Bits needed to hold values 0..n-1, never less than one
   function automatic int clog2_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/conv23_pool_write_controller_maxpool_channel_buffer.sv
// Per-channel running-max storage for one 2x2 pooling window.
// Read is combinational at idx; a write either loads wr_data or keeps
// the signed max of the stored entry and wr_data.
module conv23_pool_write_controller_maxpool_channel_buffer
   import conv23_pool_write_controller_pkg::*;
#(
   parameter int NCH = NCH_DEFAULT,
   parameter int DW  = DW_DEFAULT,
   parameter int IW  = clog2_w(NCH)
) (
   input  logic          clk,
   input  logic [IW-1:0] idx,
   input  logic          wr_en,
   input  logic          load_sel,
   input  logic [DW-1:0] wr_data,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem_q [NCH];
   logic [DW-1:0] wr_val_d;

   assign rd_data = mem_q[idx];

   // Next entry value: fresh load on the first quadrant, signed max otherwise
   always_comb begin
      wr_val_d = wr_data;
      if (!load_sel && ($signed(rd_data) > $signed(wr_data))) wr_val_d = rd_data;
   end

   // Contents need no reset: the first quadrant always overwrites them
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[idx] <= wr_val_d;
   end

endmodule

// File: rtl/conv23_pool_write_controller.sv
// Write-side controller for CONV2/CONV3: 2x2 max-pool (optional ReLU) of a
// conv stream ordered j, i, quadrant, channel (innermost), written to the
// next layer's feature memory in channel-planar order.
module conv23_pool_write_controller
   import conv23_pool_write_controller_pkg::*;
#(
   parameter int DW     = DW_DEFAULT,
   parameter int NCH    = NCH_DEFAULT,
   parameter int WIDTH  = CONV2_WIDTH,
   parameter int HEIGHT = CONV2_HEIGHT,
   parameter int AW     = 13,
   parameter int RELU   = 1
) (
   input  logic          iCLK,
   input  logic          iRSTn,
   input  logic          iVALID,
   input  logic [DW-1:0] iDATA,
   output logic          oWr_EN,
   output logic [AW-1:0] oWr_ADDR,
   output logic [DW-1:0] oWr_DATA,
   output logic          oWr_DONE
);

   localparam int OW = WIDTH / 2;
   localparam int OH = HEIGHT / 2;
   localparam int CW = clog2_w(NCH);
   localparam int IW = clog2_w(OW);
   localparam int JW = clog2_w(OH);

   logic [CW-1:0] ch_q, ch_d;
   pool_quad_e    q_q, q_d;
   logic [IW-1:0] i_q, i_d;
   logic [JW-1:0] j_q, j_d;

   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic          wr_done_q, wr_done_d;

   logic          ch_last, q_last, i_last, j_last;
   logic [DW-1:0] buf_rd, pool_max, pool_out;
   logic [AW-1:0] pos_addr;

   assign ch_last = (ch_q == CW'(NCH - 1));
   assign q_last  = (q_q == POOL_Q3);
   assign i_last  = (i_q == IW'(OW - 1));
   assign j_last  = (j_q == JW'(OH - 1));

   // Nested position counters, advancing only on accepted samples
   always_comb begin
      ch_d = ch_q;
      q_d  = q_q;
      i_d  = i_q;
      j_d  = j_q;
      if (iVALID) begin
         if (ch_last) begin
            ch_d = '0;
            if (q_last) begin
               q_d = POOL_Q0;
               if (i_last) begin
                  i_d = '0;
                  j_d = j_last ? '0 : j_q + JW'(1);
               end else begin
                  i_d = i_q + IW'(1);
               end
            end else begin
               q_d = pool_quad_e'(q_q + 2'd1);
            end
         end else begin
            ch_d = ch_q + CW'(1);
         end
      end
   end

   conv23_pool_write_controller_maxpool_channel_buffer #(
      .NCH (NCH),
      .DW  (DW),
      .IW  (CW)
   ) u_buf (
      .clk      (iCLK),
      .idx      (ch_q),
      .wr_en    (iVALID && !q_last),
      .load_sel (q_q == POOL_Q0),
      .wr_data  (iDATA),
      .rd_data  (buf_rd)
   );

   // Final quadrant: max of stored value and incoming sample, then ReLU
   always_comb begin
      pool_max = ($signed(buf_rd) > $signed(iDATA)) ? buf_rd : iDATA;
      pool_out = pool_max;
      if ((RELU != 0) && pool_max[DW-1]) pool_out = '0;
   end

   // Modulo-2^AW arithmetic equals the full-precision address truncated to AW
   assign pos_addr = AW'(ch_q) * AW'(OW * OH) + AW'(j_q) * AW'(OW) + AW'(i_q);

   // Write port: strobe on the final quadrant, address/data hold otherwise
   always_comb begin
      wr_en_d   = iVALID && q_last;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_done_d = 1'b0;
      if (wr_en_d) begin
         wr_addr_d = pos_addr;
         wr_data_d = pool_out;
         wr_done_d = ch_last && i_last && j_last;
      end
   end

   // State and output registers
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         ch_q      <= '0;
         q_q       <= POOL_Q0;
         i_q       <= '0;
         j_q       <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_done_q <= 1'b0;
      end else begin
         ch_q      <= ch_d;
         q_q       <= q_d;
         i_q       <= i_d;
         j_q       <= j_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_done_q <= wr_done_d;
      end
   end

   assign oWr_EN   = wr_en_q;
   assign oWr_ADDR = wr_addr_q;
   assign oWr_DATA = wr_data_q;
   assign oWr_DONE = wr_done_q;

endmodule

// File: tb/tb_conv23_pool_write_controller.sv
// Bench for conv23_pool_write_controller: three instances (small RELU=0,
// small RELU=1, default CONV2 geometry) share one input stream; an
// arithmetic reference model predicts every write and a monitor checks it.
module tb_conv23_pool_write_controller;

   // ---------------- clock / reset ----------------
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [15:0] din   = '0;
   int          cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        en0, en1, en2, done0, done1, done2;
   logic [2:0]  a0, a1;
   logic [12:0] a2;
   logic [15:0] d0, d1, d2;

   conv23_pool_write_controller #(.DW(16), .NCH(2), .WIDTH(4), .HEIGHT(4), .AW(3), .RELU(0)) u_small0 (
      .iCLK(clk), .iRSTn(rst_n), .iVALID(valid), .iDATA(din),
      .oWr_EN(en0), .oWr_ADDR(a0), .oWr_DATA(d0), .oWr_DONE(done0));

   conv23_pool_write_controller #(.DW(16), .NCH(2), .WIDTH(4), .HEIGHT(4), .AW(3), .RELU(1)) u_small1 (
      .iCLK(clk), .iRSTn(rst_n), .iVALID(valid), .iDATA(din),
      .oWr_EN(en1), .oWr_ADDR(a1), .oWr_DATA(d1), .oWr_DONE(done1));

   conv23_pool_write_controller #(.DW(16), .NCH(112), .WIDTH(14), .HEIGHT(18), .AW(13), .RELU(1)) u_full (
      .iCLK(clk), .iRSTn(rst_n), .iVALID(valid), .iDATA(din),
      .oWr_EN(en2), .oWr_ADDR(a2), .oWr_DATA(d2), .oWr_DONE(done2));

   // ---------------- scoreboard state ----------------
   int tests = 0;
   int fails = 0;

   // entry: {expected cycle[31:0], addr[15:0], data[15:0], done}
   logic [64:0] exp_q0[$];
   logic [64:0] exp_q1[$];
   logic [64:0] exp_q2[$];

   int          acc [3][112];
   int          cnt [3];
   logic [15:0] last_addr [3];
   logic [15:0] last_data [3];
   int          full_writes    = 0;
   int          full_done_cnt  = 0;
   bit          full_after_done = 1'b0;
   bit          full_after_rst  = 1'b0;

   int          t1 [8] = '{3, -2, -5, -7, 9, -1, 1, -4};
   logic [15:0] te [8] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h8000,
                           16'h0000, 16'h8000, 16'h7FFF, 16'h8000};

   function automatic int nch_of(input int k); return (k == 2) ? 112 : 2; endfunction
   function automatic int ow_of (input int k); return (k == 2) ? 7 : 2;   endfunction
   function automatic int oh_of (input int k); return (k == 2) ? 9 : 2;   endfunction
   function automatic int aw_of (input int k); return (k == 2) ? 13 : 3;  endfunction
   function automatic bit relu_of(input int k); return (k != 0);          endfunction

   function automatic void push_exp(input int k, input logic [64:0] v);
      case (k)
         0:       exp_q0.push_back(v);
         1:       exp_q1.push_back(v);
         default: exp_q2.push_back(v);
      endcase
   endfunction

   function automatic int qsize(input int k);
      case (k)
         0:       return exp_q0.size();
         1:       return exp_q1.size();
         default: return exp_q2.size();
      endcase
   endfunction

   function automatic logic [64:0] pop_exp(input int k);
      case (k)
         0:       return exp_q0.pop_front();
         1:       return exp_q1.pop_front();
         default: return exp_q2.pop_front();
      endcase
   endfunction

   task automatic chk(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   // Reference model: position derived from the sample's index in its frame
   task automatic model_step(input int k, input logic [15:0] d);
      int nch, ow, oh, frame, n, ch, q, pos, i, j, sd, m, addr;
      logic done;
      nch   = nch_of(k);
      ow    = ow_of(k);
      oh    = oh_of(k);
      frame = nch * 4 * ow * oh;
      n     = cnt[k];
      ch    = n % nch;
      q     = (n / nch) % 4;
      pos   = n / (4 * nch);
      i     = pos % ow;
      j     = pos / ow;
      sd    = int'($signed(d));
      if (q == 0) begin
         acc[k][ch] = sd;
      end else if (q < 3) begin
         if (sd > acc[k][ch]) acc[k][ch] = sd;
      end else begin
         m = (sd > acc[k][ch]) ? sd : acc[k][ch];
         if (relu_of(k) && m < 0) m = 0;
         addr = (ch * ow * oh + j * ow + i) % (1 << aw_of(k));
         done = (n == frame - 1);
         push_exp(k, {32'(cyc + 1), 16'(addr), 16'(m), done});
      end
      cnt[k] = (n + 1) % frame;
   endtask

   // ---------------- monitor ----------------
   task automatic check_out(input int k, input logic en, input logic [15:0] addr,
                            input logic [15:0] data, input logic done);
      logic [64:0] e;
      if (en) begin
         tests++;
         if (qsize(k) == 0) begin
            fails++;
            $display("FAIL write%0d: unexpected write addr=%0d data=%h at cyc %0d", k, addr, data, cyc);
         end else begin
            e = pop_exp(k);
            if (e[64:33] != 32'(cyc) || e[32:17] != addr || e[16:1] != data || e[0] != done) begin
               fails++;
               $display("FAIL write%0d: got addr=%0d data=%h done=%b cyc=%0d, expected addr=%0d data=%h done=%b cyc=%0d",
                        k, addr, data, done, cyc, e[32:17], e[16:1], e[0], e[64:33]);
            end
         end
         last_addr[k] = addr;
         last_data[k] = data;
         if (k == 2) begin
            full_writes++;
            if (full_after_done || full_after_rst) begin
               chk("full_first_addr", int'(addr), 0);
               full_after_done = 1'b0;
               full_after_rst  = 1'b0;
            end
            if (done) begin
               chk("full_frame_writes", full_writes, 7056);
               chk("full_last_addr", int'(addr), 7055);
               full_done_cnt++;
               full_writes     = 0;
               full_after_done = 1'b1;
            end
         end
      end else begin
         tests++;
         if (addr != last_addr[k] || data != last_data[k] || done) begin
            fails++;
            $display("FAIL idle%0d: got addr=%0d data=%h done=%b, expected addr=%0d data=%h done=0",
                     k, addr, data, done, last_addr[k], last_data[k]);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check_out(0, en0, 16'(a0), d0, done0);
         check_out(1, en1, 16'(a1), d1, done1);
         check_out(2, en2, 16'(a2), d2, done2);
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic [15:0] d);
      @(negedge clk);
      valid = v;
      din   = v ? d : 16'($urandom);
      if (v) for (int k = 0; k < 3; k++) model_step(k, d);
   endtask

   function automatic logic [15:0] gen_data(input int s);
      if (s < 8)  return 16'(t1[s]);
      if (s < 32) return 16'($urandom);
      if (s < 64) return 16'(-int'($urandom_range(1, 3000)));
      if (s < 72) return te[s - 64];
      return 16'($urandom);
   endfunction

   task automatic send_sample(input int s);
      if (s >= 100 && s < 1000 && (s % 2) == 1) begin
         drive(1'b0, 16'h0);
         drive(1'b0, 16'h0);
      end else if (s >= 1000 && s < 2000 && $urandom_range(0, 3) == 0) begin
         drive(1'b0, 16'h0);
      end
      drive(1'b1, gen_data(s));
   endtask

   task automatic check_reset_outputs();
      chk("rst_en0",   int'(en0),   0);
      chk("rst_addr0", int'(a0),    0);
      chk("rst_data0", int'(d0),    0);
      chk("rst_done0", int'(done0), 0);
      chk("rst_en1",   int'(en1),   0);
      chk("rst_addr1", int'(a1),    0);
      chk("rst_data1", int'(d1),    0);
      chk("rst_done1", int'(done1), 0);
      chk("rst_en2",   int'(en2),   0);
      chk("rst_addr2", int'(a2),    0);
      chk("rst_data2", int'(d2),    0);
      chk("rst_done2", int'(done2), 0);
   endtask

   task automatic clear_model();
      for (int k = 0; k < 3; k++) begin
         cnt[k]       = 0;
         last_addr[k] = '0;
         last_data[k] = '0;
      end
      full_writes     = 0;
      full_after_done = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      clear_model();
      repeat (3) @(negedge clk);
      check_reset_outputs();
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Full default frame (28224 samples) plus frame 2 up to q=2 of position (3,2)
      for (int s = 0; s < 36069; s++) send_sample(s);
      drive(1'b0, 16'h0);
      drive(1'b0, 16'h0);

      @(negedge clk);
      #2 rst_n = 1'b0;
      for (int k = 0; k < 3; k++) chk("pending_before_rst", qsize(k), 0);
      chk("full_done_pulses", full_done_cnt, 1);
      clear_model();
      repeat (2) @(negedge clk);
      check_reset_outputs();
      full_after_rst = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Fresh frame after mid-frame reset
      for (int s = 0; s < 1000; s++) begin
         if ($urandom_range(0, 4) == 0) drive(1'b0, 16'h0);
         drive(1'b1, 16'($urandom));
      end
      repeat (3) drive(1'b0, 16'h0);
      for (int k = 0; k < 3; k++) chk("pending_at_end", qsize(k), 0);
      chk("full_rst_first_write_seen", int'(full_after_rst), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
